// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// mips_alu : registered EX-stage MIPS ALU, 1-cycle latency; `ALU_OVERFLOW_EN`
//            adds a registered signed-overflow flag for ADD/SUB.  Rev 1.0
// ============================================================================
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       aluCtr,
    output logic [WIDTH-1:0] aluRes,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SH = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [SH-1:0]    shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] result;

    assign shamt       = input1[SH-1:0];
    assign sum         = input1 + input2;
    assign diff        = input1 - input2;
    assign lt_signed   = $signed(input1) < $signed(input2);
    assign lt_unsigned = input1 < input2;

    always_comb begin
        result = '0;
        case (aluCtr)
            OP_AND:  result = input1 & input2;
            OP_OR:   result = input1 | input2;
            OP_ADD:  result = sum;
            OP_XOR:  result = input1 ^ input2;
            OP_SLL:  result = input2 << shamt;
            OP_SRL:  result = input2 >> shamt;
            OP_SUB:  result = diff;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SRA:  result = $signed(input2) >>> shamt;
            OP_LUI:  result = input2 << (WIDTH/2);
            OP_NOR:  result = ~(input1 | input2);
            default: result = '0;
        endcase
    end

    // zero follows the value being loaded, not the value already held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluRes <= '0;
            zero   <= 1'b1;
        end else begin
            aluRes <= result;
            zero   <= (result == '0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        case (aluCtr)
            OP_ADD:  ovf_next = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                                (sum[WIDTH-1] != input1[WIDTH-1]);
            OP_SUB:  ovf_next = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                                (diff[WIDTH-1] != input1[WIDTH-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// ============================================================================
// tb_mips_alu : directed + randomized check of mips_alu against an arithmetic
//               reference model.  Rev 1.0
// ============================================================================
module tb_mips_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [3:0]       aluCtr;
    logic [WIDTH-1:0] aluRes;
    logic             zero;
`ifdef ALU_OVERFLOW_EN
    logic             overflow;
`endif

    int tests_run;
    int tests_failed;

    mips_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .input1 (input1),
        .input2 (input2),
        .aluCtr (aluCtr),
        .aluRes (aluRes),
        .zero   (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: shifts as multiply/divide by powers of two, compares on
    // sign-extended 64-bit integers.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [3:0] op);
        longint ua, ub, sa, sb, md, p2, q;
        int s;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        md = longint'(64'd1 << WIDTH);
        s  = int'(ua % WIDTH);
        p2 = longint'(64'd1 << s);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return WIDTH'((ua + ub) % md);
            4'd3:  return a ^ b;
            4'd4:  return WIDTH'((ub * p2) % md);
            4'd5:  return WIDTH'(ub / p2);
            4'd6:  return WIDTH'((ua - ub + md) % md);
            4'd7:  return (sa < sb) ? WIDTH'(1) : WIDTH'(0);
            4'd8:  return (ua < ub) ? WIDTH'(1) : WIDTH'(0);
            4'd9: begin
                q = sb / p2;
                if (sb < 0 && (sb % p2) != 0) q = q - 1;
                return WIDTH'(q);
            end
            4'd10: return WIDTH'((ub * (longint'(1) << (WIDTH/2))) % md);
            4'd12: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [3:0] op);
        longint sa, sb, r, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(64'd1 << (WIDTH-1));
        if (op == 4'd2)      r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else                 return 1'b0;
        return (r >= lim) || (r < -lim);
    endfunction

    // Apply at negedge, check one posedge later against the model and,
    // when use_lit is set, against a hand-derived constant as well.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [3:0] op,
                          input logic use_lit, input logic [WIDTH-1:0] lit);
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        input1 = a;
        input2 = b;
        aluCtr = op;
        exp    = ref_alu(a, b, op);
        @(posedge clk);
        #1;
        check({tag, ".res"}, 64'(aluRes), 64'(exp));
        check({tag, ".zero"}, 64'(zero), 64'(exp == '0));
        if (use_lit) check({tag, ".lit"}, 64'(aluRes), 64'(lit));
`ifdef ALU_OVERFLOW_EN
        check({tag, ".ovf"}, 64'(overflow), 64'(ref_ovf(a, b, op)));
`endif
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            4:       return WIDTH'($urandom_range(0, 40));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        input1 = '0;
        input2 = '0;
        aluCtr = 4'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            input1 = WIDTH'($urandom);
            input2 = WIDTH'($urandom);
            aluCtr = 4'($urandom);
        end
        @(negedge clk);
        check("rst.res", 64'(aluRes), 64'd0);
        check("rst.zero", 64'(zero), 64'd1);
`ifdef ALU_OVERFLOW_EN
        check("rst.ovf", 64'(overflow), 64'd0);
`endif
        rst_n = 1'b1;

        run_op("add_first", 32'd1, 32'd1, 4'b0010, 1'b1, 32'd2);
        run_op("sub_eq",    32'd1, 32'd1, 4'b0110, 1'b1, 32'd0);
        run_op("sub_one",   32'd2, 32'd1, 4'b0110, 1'b1, 32'd1);
        run_op("sub_wrap",  32'd0, 32'd1, 4'b0110, 1'b1, 32'hFFFF_FFFF);
        run_op("and",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 1'b1, 32'h00F0_00F0);
        run_op("or",   32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 1'b1, 32'hFFF0_FFF0);
        run_op("xor",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0011, 1'b1, 32'hFF00_FF00);
        run_op("nor",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1100, 1'b1, 32'h000F_000F);
        run_op("slt",  32'h8000_0000, 32'd1, 4'b0111, 1'b1, 32'd1);
        run_op("sltu", 32'h8000_0000, 32'd1, 4'b1000, 1'b1, 32'd0);
        run_op("sra",  32'd4, 32'h8000_0000, 4'b1001, 1'b1, 32'hF800_0000);
        run_op("srl",  32'd4, 32'h8000_0000, 4'b0101, 1'b1, 32'h0800_0000);
        run_op("sll31", 32'd31, 32'd1, 4'b0100, 1'b1, 32'h8000_0000);
        run_op("sll0", 32'd0, 32'hDEAD_BEEF, 4'b0100, 1'b1, 32'hDEAD_BEEF);
        run_op("lui",  32'hFFFF_FFFF, 32'h0000_1234, 4'b1010, 1'b1, 32'h1234_0000);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b1, 32'd0);
        run_op("undef_f", 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 1'b1, 32'd0);
        run_op("undef_b", 32'hFFFF_FFFF, 32'h1, 4'b1011, 1'b1, 32'd0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'b0010, 1'b1, 32'h8000_0000);
        run_op("sub_ovf", 32'h8000_0000, 32'd1, 4'b0110, 1'b1, 32'h7FFF_FFFF);

        // Asynchronous reset between edges with an operation in flight
        run_op("pre_rst", 32'd5, 32'd6, 4'b0010, 1'b1, 32'd11);
        input1 = 32'd7;
        input2 = 32'd8;
        aluCtr = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        check("async.res", 64'(aluRes), 64'd0);
        check("async.zero", 64'(zero), 64'd1);
        @(posedge clk);
        #1;
        check("held.res", 64'(aluRes), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 32'd9, 32'd3, 4'b0110, 1'b1, 32'd6);

        for (int i = 0; i < 300; i++) begin
            run_op("rand", rand_operand(), rand_operand(), 4'($urandom), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 32-bit integer ALU for the single-cycle/pipelined MIPS CPU datapath (EX stage).
- Takes two operands and a 4-bit ALU control code from the ALU control unit.
- Produces a result plus a zero flag (used for BEQ/BNE), both registered on the rising clock edge.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥8 and even. Shift amount width = clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- input1  input  WIDTH  operand A (rs); low clog2(WIDTH) bits give the shift amount for shifts
- input2  input  WIDTH  operand B (rt / immediate); value being shifted for shifts
- aluCtr  input  4  operation select
- aluRes  output  WIDTH  registered result
- zero  output  1  registered flag, 1 when the result being registered equals 0
- overflow  output  1  only when ALU_OVERFLOW_EN is defined (see Optional Feature)

Behaviour:
- Reset: while rst_n=0, asynchronously aluRes=0 and zero=1 (and overflow=0 if present). On the first rising clk after release, the registers load normally.
- Latency: exactly 1 cycle. Inputs sampled at posedge N appear on the outputs after posedge N. No handshake; the registers load every cycle.
- aluCtr decode (result computed combinationally, then registered):
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH, carry discarded
  - 0011 XOR: A ^ B
  - 0100 SLL: B << A[sh-1:0]
  - 0101 SRL: B >> A[sh-1:0], logical
  - 0110 SUB: A - B, modulo 2^WIDTH
  - 0111 SLT: 1 if $signed(A) < $signed(B), else 0; zero-extended to WIDTH
  - 1000 SLTU: 1 if A < B unsigned, else 0
  - 1001 SRA: $signed(B) >>> A[sh-1:0], sign-filled
  - 1010 LUI: B << (WIDTH/2); A is ignored
  - 1100 NOR: ~(A | B)
  - 1011, 1101, 1110, 1111: result 0, so zero=1
- zero is derived from the same combinational result as aluRes, never from the previous registered value.
- Boundaries:
  - SUB 0x0 - 0x1 = 0xFFFFFFFF, zero=0.
  - ADD 0xFFFFFFFF + 1 = 0, zero=1.
  - Shift by 0 passes B unchanged; a shift amount of 31 is valid.
  - SLT 0x80000000 vs 0x1 gives 1; SLTU with the same operands gives 0.
- Reset asserted mid-stream clears the outputs immediately. The in-flight operation is lost, not replayed.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds a 1-bit registered output overflow, reset to 0.
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when operand signs differ and the result sign differs from A.
  - All other ops: 0.
  - Same 1-cycle latency as aluRes. aluRes is still the wrapped value.
- Not defined: the port and its logic are absent, and every other behaviour is unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> aluRes=0, zero=1. Release, apply 1,1,0010 -> after one posedge aluRes=2, zero=0.
- SUB path: (1,1,0110) -> aluRes=0, zero=1. Next cycle (2,1,0110) -> aluRes=1, zero=0. Each result appears exactly one posedge after it is applied.
- Logic ops on A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND -> 0x00F000F0
  - OR -> 0xFFF0FFF0
  - XOR -> 0xFF00FF00
  - NOR -> 0x000F000F
- Compares/shifts:
  - SLT(0x80000000,1) -> 1; SLTU(0x80000000,1) -> 0
  - SRA(A=4, B=0x80000000) -> 0xF8000000; SRL same operands -> 0x08000000
  - SLL(A=31, B=1) -> 0x80000000
  - LUI(B=0x1234) -> 0x12340000
- Wrap and undefined codes: ADD(0xFFFFFFFF,1) -> 0, zero=1. aluCtr=1111 -> 0, zero=1. With ALU_OVERFLOW_EN: ADD(0x7FFFFFFF,1) -> 0x80000000, overflow=1.
- Async reset mid-operation: drop rst_n between edges -> outputs clear without waiting for clk. Re-release, then a new op completes after one posedge.
